adc_axi_mc: RTL

ADC_AXI_MC -- requirements
Module: adc_axi_mc

---
 rtl/adc_axi_mc_pkg.sv | 30 +++
 rtl/adc_axi_mc_fifo.sv | 50 +++++
 rtl/adc_axi_mc.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_axi_mc_pkg.sv
// adc_axi_mc shared definitions: register offsets, response codes,
// STATUS bit positions and FIFO-entry field layout.
package adc_axi_mc_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_FIFO   = 8'h08;
    localparam logic [7:0] ADDR_LAST   = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int FE_VALID  = 31;
    localparam int FE_CH_LSB = 16;
    localparam int FE_CH_W   = 3;

    localparam int CTRL_IRQ_EN = 31;
    localparam int LAST_NEW    = 31;

    // Byte offset of the LAST register belonging to channel c.
    function automatic logic [7:0] last_addr(input int c);
        return ADDR_LAST + 8'(4 * c);
    endfunction

endpackage

// File: rtl/adc_axi_mc_fifo.sv
// Sample FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Push and pop in the same cycle succeed even when full.
module adc_axi_mc_fifo #(
    parameter int width = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic [width-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/adc_axi_mc.sv
// Multi-channel ADC capture with AXI4-Lite register access.
// Define ADC_AXI_MC_FIFO_EN to add the sample FIFO, arbiter and IRQ.
import adc_axi_mc_pkg::*;

module adc_axi_mc #(
    parameter int sword    = 32,
    parameter int CHANNELS = 4,
    parameter int ADC_BITS = 10,
    parameter int DEPTH    = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CHANNELS-1:0]          ADC_BUSY,
    input  logic [CHANNELS*ADC_BITS-1:0] ADC_DATA,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [sword-1:0]             AWADDR,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [sword-1:0]             WDATA,
    input  logic [sword/8-1:0]           WSTRB,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [1:0]                   BRESP,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    input  logic [sword-1:0]             ARADDR,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [sword-1:0]             RDATA,
    output logic [1:0]                   RRESP,
    output logic                         IRQ
);

    logic [CHANNELS-1:0] s1_q, s2_q, s3_q, fall;
    logic [CHANNELS-1:0] enable_q, new_q, new_d, rd_clr;
    logic [ADC_BITS-1:0] last_q [CHANNELS];
    logic                irq_en_q, ovr_q, ovr_d, ovr_set, ovr_clr;
    logic                awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [sword-1:0]    rdata_q, rdata_d, status;
    logic                wr_hs, ar_hs, wr_ctrl, wr_stat, wr_err;
    logic                rd_err, rd_pop;
    logic                unused_ok;

    assign fall    = s3_q & ~s2_q & enable_q;
    assign wr_hs   = awready_q & AWVALID & WVALID;
    assign ar_hs   = arready_q & ARVALID;
    assign wr_ctrl = wr_hs & (AWADDR[7:0] == ADDR_CTRL);
    assign wr_stat = wr_hs & (AWADDR[7:0] == ADDR_STATUS);
    assign wr_err  = ~(AWADDR[7:0] == ADDR_CTRL ||
                       AWADDR[7:0] == ADDR_STATUS);
    assign ovr_clr = wr_stat & WSTRB[0] & WDATA[ST_OVR];
    assign ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
    assign new_d   = fall | (new_q & ~(rd_clr & {CHANNELS{ar_hs}}));

    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign unused_ok = ^{AWADDR, ARADDR, WDATA, WSTRB};

`ifdef ADC_AXI_MC_FIFO_EN
    logic [CHANNELS-1:0]    pending_q, pending_d, grant;
    logic [sword-1:0]       push_entry, f_data;
    logic                   f_full, f_empty, f_push, f_pop;
    logic [$clog2(DEPTH):0] f_count;

    assign f_push    = |grant;
    assign f_pop     = ar_hs & rd_pop;
    assign pending_d = (pending_q & ~grant) | fall;
    assign ovr_set   = |(fall & pending_q & ~grant) |
                       (f_push & f_full & ~f_pop);
    assign IRQ       = irq_en_q & ~f_empty;

    // Fixed-priority pick of the lowest pending channel.
    always_comb begin
        grant      = '0;
        push_entry = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                grant      = '0;
                grant[c]   = 1'b1;
                push_entry = '0;
                push_entry[FE_VALID] = 1'b1;
                push_entry[FE_CH_LSB +: FE_CH_W] = FE_CH_W'(c);
                push_entry[ADC_BITS-1:0] = last_q[c];
            end
        end
    end

    // STATUS view with FIFO occupancy.
    always_comb begin
        status = '0;
        status[ST_CNT_LSB +: 8] = 8'(f_count);
        status[ST_OVR]   = ovr_q;
        status[ST_FULL]  = f_full;
        status[ST_EMPTY] = f_empty;
    end

    // Pending flags waiting for a FIFO slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    adc_axi_mc_fifo #(
        .width (sword),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (f_push),
        .data_i  (push_entry),
        .pop_i   (f_pop),
        .data_o  (f_data),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );
`else
    assign ovr_set = |(fall & new_q);
    assign IRQ     = 1'b0;

    // STATUS view without FIFO: always empty.
    always_comb begin
        status = '0;
        status[ST_OVR]   = ovr_q;
        status[ST_EMPTY] = 1'b1;
    end
`endif

    // Read decode: data, error flag and read side effects.
    always_comb begin
        rdata_d = '0;
        rd_err  = 1'b0;
        rd_clr  = '0;
        rd_pop  = 1'b0;
        if (ARADDR[7:0] == ADDR_CTRL) begin
            rdata_d[CTRL_IRQ_EN]    = irq_en_q;
            rdata_d[CHANNELS-1:0]   = enable_q;
        end else if (ARADDR[7:0] == ADDR_STATUS) begin
            rdata_d = status;
        end else if (ARADDR[7:0] == ADDR_FIFO) begin
`ifdef ADC_AXI_MC_FIFO_EN
            rd_pop  = ~f_empty;
            rdata_d = f_empty ? '0 : f_data;
`else
            rd_err  = 1'b1;
`endif
        end else begin
            rd_err = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (ARADDR[7:0] == last_addr(c)) begin
                    rd_err    = 1'b0;
                    rd_clr[c] = 1'b1;
                    rdata_d[LAST_NEW]       = new_q[c];
                    rdata_d[ADC_BITS-1:0]   = last_q[c];
                end
            end
        end
    end

    // Busy synchronisers, preset so reset release is edge-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q <= '1;
            s2_q <= '1;
            s3_q <= '1;
        end else begin
            s1_q <= ADC_BUSY;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Sample capture, NEW flags, control and overrun.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int c = 0; c < CHANNELS; c++) last_q[c] <= '0;
            new_q    <= '0;
            enable_q <= '1;
            irq_en_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (fall[c])
                    last_q[c] <= ADC_DATA[c*ADC_BITS +: ADC_BITS];
            end
            new_q <= new_d;
            ovr_q <= ovr_d;
            if (wr_ctrl && WSTRB[0]) enable_q <= WDATA[CHANNELS-1:0];
            if (wr_ctrl && WSTRB[3]) irq_en_q <= WDATA[CTRL_IRQ_EN];
        end
    end

    // AXI write handshake and response.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= AWVALID & WVALID & ~bvalid_q & ~awready_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // AXI read handshake and registered response.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= ARVALID & ~rvalid_q & ~arready_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
